// File: rtl/procesador_pkg.sv
// procesador_pkg: fetch sequencer state encoding and default widths
package procesador_pkg;
  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    ESPERAR  = 2'd1,
    DETENIDO = 2'd2
  } estado_t;
  localparam int ANCHO_DEF      = 64;
  localparam int INCREMENTO_DEF = 4;
endpackage

// File: rtl/calc_siguiente_pc.sv
// calc_siguiente_pc: next-PC mux (aligned branch target / PC+step / hold) and misalignment detect
module calc_siguiente_pc #(
  parameter int ANCHO      = 64,
  parameter int INCREMENTO = 4
) (
  input  logic [ANCHO-1:0] pc,
  input  logic             avanzar,
  input  logic             salto_valido,
  input  logic [ANCHO-1:0] direccion_salto,
  output logic [ANCHO-1:0] pc_siguiente,
  output logic             desalineado
);
  always_comb begin
    pc_siguiente = salto_valido ? {direccion_salto[ANCHO-1:2], 2'b00}
                 : avanzar      ? pc + ANCHO'(INCREMENTO)
                 : pc;
    desalineado  = salto_valido & |direccion_salto[1:0];
  end
endmodule

// File: rtl/secuenciador_pc.sv
// secuenciador_pc: fetch sequencer owning the PC, issuing instruction-memory requests
module secuenciador_pc
  import procesador_pkg::*;
#(
  parameter int               ANCHO      = ANCHO_DEF,
  parameter logic [ANCHO-1:0] DIR_RESET  = '0,
  parameter int               INCREMENTO = INCREMENTO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             detener,
  input  logic             salto_valido,
  input  logic [ANCHO-1:0] direccion_salto,
  input  logic             im_listo,
  output logic             im_solicitud,
  output logic [ANCHO-1:0] im_direccion,
  output logic             instruccion_valida,
  output logic [ANCHO-1:0] pc_instruccion,
  output logic [31:0]      contador_instrucciones,
  output logic             salto_desalineado
);
  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] pc_q, pc_d, pc_instr_q, pc_instr_d;
  logic [31:0]      contador_q, contador_d;
  logic             valida_q, valida_d, desal_q, desal_d, desalineado, completa;

  calc_siguiente_pc #(.ANCHO(ANCHO), .INCREMENTO(INCREMENTO)) u_calc (
    .pc              (pc_q),
    .avanzar         (completa),
    .salto_valido    (salto_valido),
    .direccion_salto (direccion_salto),
    .pc_siguiente    (pc_d),
    .desalineado     (desalineado)
  );

  // a branch in the completing cycle makes the fetch wrong-path, so it is not counted
  always_comb begin
    completa   = (estado_q == ESPERAR) & im_listo & ~salto_valido;
    estado_d   = salto_valido ? estado_q
               : (estado_q == INACTIVO) ? ((habilitar & ~detener) ? ESPERAR : INACTIVO)
               : (estado_q == ESPERAR)  ? (~im_listo ? ESPERAR
                                           : detener ? DETENIDO
                                           : habilitar ? ESPERAR : INACTIVO)
               : (estado_q == DETENIDO) ? (detener ? DETENIDO
                                           : habilitar ? ESPERAR : INACTIVO)
               : INACTIVO;
    valida_d   = completa;
    pc_instr_d = completa ? pc_q : pc_instr_q;
    contador_d = contador_q + 32'(completa);
    desal_d    = desalineado;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= INACTIVO;
      pc_q       <= DIR_RESET;
      pc_instr_q <= '0;
      contador_q <= '0;
      valida_q   <= 1'b0;
      desal_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      pc_instr_q <= pc_instr_d;
      contador_q <= contador_d;
      valida_q   <= valida_d;
      desal_q    <= desal_d;
    end
  end

  assign im_solicitud           = estado_q == ESPERAR;
  assign im_direccion           = pc_q;
  assign instruccion_valida     = valida_q;
  assign pc_instruccion         = pc_instr_q;
  assign contador_instrucciones = contador_q;
  assign salto_desalineado      = desal_q;
endmodule

// File: tb/tb_secuenciador_pc.sv
// tb_secuenciador_pc: directed stimulus with a scoreboard of expected completed fetches
module tb_secuenciador_pc;
  logic        clk = 0, reset = 1, habilitar = 0, detener = 0, salto_valido = 0, im_listo = 0;
  logic [63:0] direccion_salto = '0;
  logic        im_solicitud, instruccion_valida, salto_desalineado;
  logic [63:0] im_direccion, pc_instruccion;
  logic [31:0] contador_instrucciones;
  int          errors = 0, checks = 0;
  logic [95:0] esperado[$];

  secuenciador_pc dut (
    .clk                    (clk),
    .reset                  (reset),
    .habilitar              (habilitar),
    .detener                (detener),
    .salto_valido           (salto_valido),
    .direccion_salto        (direccion_salto),
    .im_listo               (im_listo),
    .im_solicitud           (im_solicitud),
    .im_direccion           (im_direccion),
    .instruccion_valida     (instruccion_valida),
    .pc_instruccion         (pc_instruccion),
    .contador_instrucciones (contador_instrucciones),
    .salto_desalineado      (salto_desalineado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nombre, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int lat, input logic [63:0] pc, input logic [31:0] cnt);
    for (int i = 0; i < lat; i++) begin
      chk("req_wait", 64'(im_solicitud), 64'd1);
      chk("addr_wait", im_direccion, pc);
      tick();
    end
    chk("req", 64'(im_solicitud), 64'd1);
    chk("addr", im_direccion, pc);
    im_listo = 1;
    esperado.push_back({cnt, pc});
    tick();
    im_listo = 0;
  endtask

  always @(negedge clk) begin
    if (instruccion_valida) begin
      if (esperado.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: pc_instruccion %h with empty scoreboard", pc_instruccion);
      end else begin
        logic [95:0] e;
        e = esperado.pop_front();
        chk("valid_pc", pc_instruccion, e[63:0]);
        chk("valid_count", 64'(contador_instrucciones), 64'(e[95:64]));
      end
    end
  end

  initial begin
    #1;
    chk("rst_req", 64'(im_solicitud), 64'd0);
    chk("rst_addr", im_direccion, 64'd0);
    chk("rst_valid", 64'(instruccion_valida), 64'd0);
    chk("rst_count", 64'(contador_instrucciones), 64'd0);
    tick();
    reset = 0;
    habilitar = 1;
    tick();
    fetch(1, 64'h0, 1);
    fetch(1, 64'h4, 2);
    detener = 1;
    fetch(2, 64'h8, 3);
    chk("stall_req", 64'(im_solicitud), 64'd0);
    chk("stall_addr", im_direccion, 64'hC);
    chk("stall_count", 64'(contador_instrucciones), 64'd3);
    tick();
    chk("stall_hold_req", 64'(im_solicitud), 64'd0);
    detener = 0;
    tick();
    chk("release_req", 64'(im_solicitud), 64'd1);
    chk("release_addr", im_direccion, 64'hC);
    im_listo = 1;
    salto_valido = 1;
    direccion_salto = 64'h100;
    tick();
    im_listo = 0;
    salto_valido = 0;
    chk("wrongpath_valid", 64'(instruccion_valida), 64'd0);
    chk("wrongpath_count", 64'(contador_instrucciones), 64'd3);
    chk("branch_addr", im_direccion, 64'h100);
    chk("branch_desal", 64'(salto_desalineado), 64'd0);
    fetch(1, 64'h100, 4);
    salto_valido = 1;
    direccion_salto = 64'h40;
    tick();
    salto_valido = 0;
    chk("restart_addr", im_direccion, 64'h40);
    habilitar = 0;
    fetch(1, 64'h40, 5);
    chk("idle_req", 64'(im_solicitud), 64'd0);
    chk("idle_addr", im_direccion, 64'h44);
    salto_valido = 1;
    direccion_salto = 64'h206;
    tick();
    salto_valido = 0;
    chk("misal_addr", im_direccion, 64'h204);
    chk("misal_pulse", 64'(salto_desalineado), 64'd1);
    chk("misal_req", 64'(im_solicitud), 64'd0);
    tick();
    chk("misal_pulse_end", 64'(salto_desalineado), 64'd0);
    chk("misal_state", 64'(im_solicitud), 64'd0);
    salto_valido = 1;
    direccion_salto = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    salto_valido = 0;
    habilitar = 1;
    tick();
    fetch(1, 64'hFFFF_FFFF_FFFF_FFFC, 6);
    chk("wrap_addr", im_direccion, 64'h0);
    chk("wrap_req", 64'(im_solicitud), 64'd1);
    salto_valido = 1;
    direccion_salto = 64'h80;
    tick();
    salto_valido = 0;
    chk("pre_reset_addr", im_direccion, 64'h80);
    #2 reset = 1;
    #1;
    chk("async_req", 64'(im_solicitud), 64'd0);
    chk("async_addr", im_direccion, 64'd0);
    chk("async_count", 64'(contador_instrucciones), 64'd0);
    tick();
    tick();
    reset = 0;
    tick();
    chk("scoreboard_empty", 64'(esperado.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
